// File: rtl/sdram_startup_pkg.sv
// sdram_startup_pkg: shared state encoding, retry width and seconds-to-cycles conversion
package sdram_startup_pkg;
   typedef enum logic [2:0] {IDLE, POWERUP, INIT, BACKOFF, SETTLE, READY, ERROR} state_t;
   localparam int RETRY_W = 4;
   function automatic int sec_to_cycles(real sec, real clk);
      real c;
      int n;
      c = sec * clk;
      n = $rtoi(c);
      if (real'(n) < c) n++;
      return (n < 1) ? 1 : n;
   endfunction
endpackage

// File: rtl/sdram_startup_sequencer_timer.sv
// startup_cycle_timer: loadable down-counter that saturates at zero and flags expiry
module startup_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk112M,
   input  logic         rst_n,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] load_value,
   output logic         expired
);
   logic [W-1:0] count;
   always_ff @(posedge clk112M or negedge rst_n) begin
      if (!rst_n) count <= '0;
      else if (load) count <= load_value;
      else if (enable && count != '0) count <= count - 1'b1;
   end
   assign expired = count == '0;
endmodule

// File: rtl/sdram_startup_sequencer.sv
// sdram_startup_sequencer: SDRAM bring-up sequencing with init handshake, timeout, retries and settle
module sdram_startup_sequencer
   import sdram_startup_pkg::*;
#(
   parameter real CLK            = 111857000.0,
   parameter real POWERUP_S      = 0.201,
   parameter real INIT_TIMEOUT_S = 0.025,
   parameter int  SETTLE_CYCLES  = 16,
   parameter int  BACKOFF_CYCLES = 64,
   parameter int  MAX_RETRIES    = 3
) (
   input  logic               clk112M,
   input  logic               rst_n,
   input  logic               start,
   input  logic               init_done,
   output logic               sdram_init_n,
   output logic               sdram_ready,
   output logic               sdram_error,
   output logic [RETRY_W-1:0] retry_count,
   output logic               busy
);
   localparam int POWERUP_CYC = sec_to_cycles(POWERUP_S, CLK);
   localparam int TIMEOUT_CYC = sec_to_cycles(INIT_TIMEOUT_S, CLK);
   localparam int MAX_A = (POWERUP_CYC > TIMEOUT_CYC) ? POWERUP_CYC : TIMEOUT_CYC;
   localparam int MAX_B = (SETTLE_CYCLES > BACKOFF_CYCLES) ? SETTLE_CYCLES : BACKOFF_CYCLES;
   localparam int CW = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;
   // Timer is loaded with duration-1 so a state lasts exactly its duration in cycles.
   localparam logic [CW-1:0] P_LD = CW'(POWERUP_CYC - 1);
   localparam logic [CW-1:0] T_LD = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] B_LD = CW'(BACKOFF_CYCLES - 1);
   localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);
   state_t state, nxt;
   logic [RETRY_W-1:0] retry_nxt;
   logic [CW-1:0] ld_val;
   logic ld, expired;
   startup_cycle_timer #(.W(CW)) u_timer (
      .clk112M(clk112M),
      .rst_n(rst_n),
      .load(ld),
      .enable(1'b1),
      .load_value(ld_val),
      .expired(expired)
   );
   always_comb begin
      nxt = state;
      retry_nxt = retry_count;
      case (state)
         IDLE:    if (start) nxt = POWERUP;
         POWERUP: if (expired) nxt = INIT;
         INIT:
            if (init_done) nxt = SETTLE;
            else if (expired && retry_count < MAX_R) begin
               nxt = BACKOFF;
               retry_nxt = retry_count + 1'b1;
            end else if (expired) nxt = ERROR;
         BACKOFF: if (expired) nxt = INIT;
         SETTLE:  if (expired) nxt = READY;
         default: ;
      endcase
      if (!start) begin
         nxt = IDLE;
         retry_nxt = '0;
      end
      ld = nxt != state;
      ld_val = nxt == POWERUP ? P_LD : nxt == INIT ? T_LD : nxt == BACKOFF ? B_LD :
               nxt == SETTLE ? S_LD : '0;
   end
   always_ff @(posedge clk112M or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         retry_count <= '0;
         sdram_init_n <= 1'b1;
         sdram_ready <= 1'b0;
         sdram_error <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= nxt;
         retry_count <= retry_nxt;
         sdram_init_n <= !(nxt inside {INIT, SETTLE, READY});
         sdram_ready <= nxt == READY;
         sdram_error <= nxt == ERROR;
         busy <= !(nxt inside {IDLE, READY, ERROR});
      end
   end
endmodule

// File: tb/tb_sdram_startup_sequencer.sv
// tb_sdram_startup_sequencer: directed scenarios with hand-computed cycle-exact expectations
module tb_sdram_startup_sequencer;
   logic clk112M = 1'b0;
   logic rst_n, start, init_done;
   logic sdram_init_n, sdram_ready, sdram_error, busy;
   logic [3:0] retry_count;
   logic [7:0] obs;
   int vectors = 0;
   int miscompares = 0;
   sdram_startup_sequencer #(
      .CLK(1000.0), .POWERUP_S(0.01), .INIT_TIMEOUT_S(0.02),
      .SETTLE_CYCLES(4), .BACKOFF_CYCLES(3), .MAX_RETRIES(2)
   ) dut (
      .clk112M(clk112M), .rst_n(rst_n), .start(start), .init_done(init_done),
      .sdram_init_n(sdram_init_n), .sdram_ready(sdram_ready), .sdram_error(sdram_error),
      .retry_count(retry_count), .busy(busy)
   );
   always #5 clk112M = ~clk112M;
   // {init_n, ready, error, busy, retry_count[3:0]}
   assign obs = {sdram_init_n, sdram_ready, sdram_error, busy, retry_count};
   task automatic tick(input int n);
      repeat (n) @(posedge clk112M);
      #1;
   endtask
   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; init_done = 1'b0;
      #12;
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL reset_hold: got %h want 80 (init_n,ready,error,busy,retry)", obs); end
      rst_n = 1'b1;
      tick(1);
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL reset_idle: got %h want 80", obs); end
   endtask
   task automatic test_nominal;
      start = 1'b1;
      tick(1);
      vectors++; if (obs !== 8'h90) begin miscompares++; $display("FAIL nom_powerup_entry: got %h want 90", obs); end
      tick(9);
      vectors++; if (obs !== 8'h90) begin miscompares++; $display("FAIL nom_powerup_last: got %h want 90", obs); end
      tick(1);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL nom_init_fall: got %h want 10", obs); end
      tick(4);
      init_done = 1'b1;
      tick(1);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL nom_settle: got %h want 10", obs); end
      tick(3);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL nom_settle_last: got %h want 10", obs); end
      tick(1);
      vectors++; if (obs !== 8'h40) begin miscompares++; $display("FAIL nom_ready: got %h want 40", obs); end
      init_done = 1'b0;
      tick(3);
      vectors++; if (obs !== 8'h40) begin miscompares++; $display("FAIL nom_ready_sticky: got %h want 40", obs); end
      start = 1'b0;
      tick(1);
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL nom_stop: got %h want 80", obs); end
   endtask
   task automatic test_retry;
      start = 1'b1; init_done = 1'b0;
      tick(30);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL retry_init_last: got %h want 10", obs); end
      tick(1);
      vectors++; if (obs !== 8'h91) begin miscompares++; $display("FAIL retry_backoff_entry: got %h want 91", obs); end
      tick(2);
      vectors++; if (obs !== 8'h91) begin miscompares++; $display("FAIL retry_backoff_last: got %h want 91", obs); end
      tick(1);
      vectors++; if (obs !== 8'h11) begin miscompares++; $display("FAIL retry_init2: got %h want 11", obs); end
      tick(1);
      init_done = 1'b1;
      tick(1);
      vectors++; if (obs !== 8'h11) begin miscompares++; $display("FAIL retry_settle: got %h want 11", obs); end
      tick(3);
      vectors++; if (obs !== 8'h11) begin miscompares++; $display("FAIL retry_settle_last: got %h want 11", obs); end
      tick(1);
      vectors++; if (obs !== 8'h41) begin miscompares++; $display("FAIL retry_ready: got %h want 41", obs); end
      start = 1'b0; init_done = 1'b0;
      tick(1);
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL retry_stop: got %h want 80", obs); end
   endtask
   task automatic test_exhaust;
      start = 1'b1; init_done = 1'b0;
      tick(31);
      vectors++; if (obs !== 8'h91) begin miscompares++; $display("FAIL exh_backoff1: got %h want 91", obs); end
      tick(3);
      vectors++; if (obs !== 8'h11) begin miscompares++; $display("FAIL exh_init2: got %h want 11", obs); end
      tick(19);
      vectors++; if (obs !== 8'h11) begin miscompares++; $display("FAIL exh_init2_last: got %h want 11", obs); end
      tick(1);
      vectors++; if (obs !== 8'h92) begin miscompares++; $display("FAIL exh_backoff2: got %h want 92", obs); end
      tick(3);
      vectors++; if (obs !== 8'h12) begin miscompares++; $display("FAIL exh_init3: got %h want 12", obs); end
      tick(19);
      vectors++; if (obs !== 8'h12) begin miscompares++; $display("FAIL exh_init3_last: got %h want 12", obs); end
      tick(1);
      vectors++; if (obs !== 8'hA2) begin miscompares++; $display("FAIL exh_error: got %h want a2", obs); end
      tick(5);
      vectors++; if (obs !== 8'hA2) begin miscompares++; $display("FAIL exh_error_hold: got %h want a2", obs); end
      start = 1'b0;
      tick(1);
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL exh_clear: got %h want 80", obs); end
   endtask
   task automatic test_abort;
      start = 1'b1; init_done = 1'b0;
      tick(15);
      init_done = 1'b1;
      tick(2);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL abort_in_settle: got %h want 10", obs); end
      start = 1'b0; init_done = 1'b0;
      tick(1);
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL abort_settle: got %h want 80", obs); end
      start = 1'b1;
      tick(10);
      vectors++; if (obs !== 8'h90) begin miscompares++; $display("FAIL abort_rerun_powerup: got %h want 90", obs); end
      tick(1);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL abort_rerun_init: got %h want 10", obs); end
      tick(21);
      vectors++; if (obs !== 8'h91) begin miscompares++; $display("FAIL abort_in_backoff: got %h want 91", obs); end
      start = 1'b0;
      tick(1);
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL abort_backoff: got %h want 80", obs); end
   endtask
   task automatic test_boundary;
      start = 1'b1; init_done = 1'b0;
      tick(30);
      init_done = 1'b1;
      tick(1);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL bound_settle: got %h want 10", obs); end
      tick(4);
      vectors++; if (obs !== 8'h40) begin miscompares++; $display("FAIL bound_ready: got %h want 40", obs); end
      start = 1'b0; init_done = 1'b0;
      tick(1);
   endtask
   task automatic test_early_done;
      start = 1'b1; init_done = 1'b1;
      tick(11);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL early_init: got %h want 10", obs); end
      tick(4);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL early_settle_last: got %h want 10", obs); end
      tick(1);
      vectors++; if (obs !== 8'h40) begin miscompares++; $display("FAIL early_ready: got %h want 40", obs); end
      start = 1'b0; init_done = 1'b0;
      tick(1);
   endtask
   task automatic test_async_reset;
      start = 1'b1; init_done = 1'b0;
      tick(16);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL ares_pre: got %h want 10", obs); end
      #3 rst_n = 1'b0;
      #1;
      vectors++; if (obs !== 8'h80) begin miscompares++; $display("FAIL ares_immediate: got %h want 80", obs); end
      #1 rst_n = 1'b1;
      tick(1);
      vectors++; if (obs !== 8'h90) begin miscompares++; $display("FAIL ares_restart: got %h want 90", obs); end
      tick(9);
      vectors++; if (obs !== 8'h90) begin miscompares++; $display("FAIL ares_powerup_last: got %h want 90", obs); end
      tick(1);
      vectors++; if (obs !== 8'h10) begin miscompares++; $display("FAIL ares_init: got %h want 10", obs); end
      start = 1'b0;
      tick(1);
   endtask
   initial begin
      test_reset;
      test_nominal;
      test_retry;
      test_exhaust;
      test_abort;
      test_boundary;
      test_early_done;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
